// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide engine: shift-add MUL and restoring DIV, one bit per clock.
// Start is accepted only in IDLE. Results and flags update only when entering DONE.
module mul_div_unit #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         Reset_n,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result_hi,
  output logic [W-1:0] result_lo,
  output logic         div_by_zero,
  output logic         op_err
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0010;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_mul_q, is_mul_d;
  logic [W-1:0]    opnd_q, opnd_d;    // multiplicand for MUL, divisor for DIV
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;      // holds the dividend, shifted out as quotient bits enter
  logic [W-1:0]    hi_d, lo_d;
  logic            dbz_d, err_d;

  logic [W:0]      sum;
  logic [W:0]      rem_sh;
  logic            fits;

  // W+1-bit add keeps the carry that the right shift brings back into the accumulator
  assign sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
  assign rem_sh = {rem_q, quo_q[W-1]};
  assign fits   = (rem_sh >= {1'b0, opnd_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    hi_d     = result_hi;
    lo_d     = result_lo;
    dbz_d    = div_by_zero;
    err_d    = op_err;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (op == OP_MUL) begin
            state_d  = RUN;
            is_mul_d = 1'b1;
            opnd_d   = a;
            acc_d    = {{W{1'b0}}, b};
            dbz_d    = 1'b0;
            err_d    = 1'b0;
          end else if (op == OP_DIV && b != '0) begin
            state_d  = RUN;
            is_mul_d = 1'b0;
            opnd_d   = b;
            rem_d    = '0;
            quo_d    = a;
            dbz_d    = 1'b0;
            err_d    = 1'b0;
          end else if (op == OP_DIV) begin
            state_d = DONE;
            hi_d    = a;
            lo_d    = {W{1'b1}};
            dbz_d   = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            hi_d    = '0;
            lo_d    = '0;
            dbz_d   = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_mul_q) begin
          acc_d = acc_q[0] ? {sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
        end else begin
          rem_d = fits ? W'(rem_sh - {1'b0, opnd_q}) : rem_sh[W-1:0];
          quo_d = {quo_q[W-2:0], fits};
        end
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
          if (is_mul_q) begin
            hi_d = acc_d[2*W-1:W];
            lo_d = acc_d[W-1:0];
          end else begin
            hi_d = rem_d;
            lo_d = quo_d;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_mul_q    <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
      op_err      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_mul_q    <= is_mul_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      result_hi   <= hi_d;
      result_lo   <= lo_d;
      div_by_zero <= dbz_d;
      op_err      <= err_d;
      busy        <= (state_d == RUN);
      done        <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus held-start and reset-abort sequences.
module tb_mul_div_unit;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         Reset_n;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero, op_err;
  logic [W-1:0] result_hi, result_lo;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit #(.W(W)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
    .div_by_zero(div_by_zero), .op_err(op_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request; inputs are scrambled after E0 so only latched copies can be used
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int nbusy, output int overlap);
    @(negedge CLK);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); op = 4'hF;
    lat = 0; nbusy = 0; overlap = 0;
    while (1) begin
      if (busy) nbusy++;
      if (busy && done) overlap++;
      if (done || lat >= 40) break;
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nbusy, overlap, ndone;
    logic [W-1:0] hold_lo;

    vecs[0]  = '{4'b0011, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 1'b0, 8};
    vecs[1]  = '{4'b0011, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 1'b0, 8};
    vecs[2]  = '{4'b0011, 8'd0,   8'd200, 8'h00, 8'h00, 1'b0, 1'b0, 8};
    vecs[3]  = '{4'b0010, 8'd200, 8'd7,   8'h04, 8'h1C, 1'b0, 1'b0, 8};
    vecs[4]  = '{4'b0010, 8'd5,   8'd9,   8'h05, 8'h00, 1'b0, 1'b0, 8};
    vecs[5]  = '{4'b0010, 8'd255, 8'd1,   8'h00, 8'hFF, 1'b0, 1'b0, 8};
    vecs[6]  = '{4'b0010, 8'h2A,  8'd0,   8'h2A, 8'hFF, 1'b1, 1'b0, 0};
    vecs[7]  = '{4'b0011, 8'd3,   8'd4,   8'h00, 8'h0C, 1'b0, 1'b0, 8};
    vecs[8]  = '{4'b0001, 8'd9,   8'd9,   8'h00, 8'h00, 1'b0, 1'b1, 0};
    vecs[9]  = '{4'b0010, 8'd255, 8'd255, 8'h00, 8'h01, 1'b0, 1'b0, 8};
    vecs[10] = '{4'b0011, 8'd128, 8'd2,   8'h01, 8'h00, 1'b0, 1'b0, 8};
    vecs[11] = '{4'b0010, 8'd100, 8'd16,  8'h04, 8'h06, 1'b0, 1'b0, 8};

    Reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", 32'(result_hi), 32'd0);
    chk("rst_lo", 32'(result_lo), 32'd0);
    chk("rst_flags", 32'({div_by_zero, op_err}), 32'd0);
    @(negedge CLK);
    Reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nbusy, overlap);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_cycles", i), 32'(nbusy), (vecs[i].lat == 0) ? 32'd0 : 32'(W));
      chk($sformatf("v%0d_busy_done_overlap", i), 32'(overlap), 32'd0);
      chk($sformatf("v%0d_hi", i), 32'(result_hi), 32'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 32'(result_lo), 32'(vecs[i].lo));
      chk($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
      chk($sformatf("v%0d_op_err", i), 32'(op_err), 32'(vecs[i].err));
      @(posedge CLK); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_lo_hold", i), 32'(result_lo), 32'(vecs[i].lo));
    end

    // Start held high: one operation per IDLE visit, period W+2
    @(negedge CLK);
    op = 4'b0011; a = 8'd6; b = 8'd7; start = 1'b1;
    ndone = 0; overlap = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge CLK); #1;
      if (done) ndone++;
      if (busy && done) overlap++;
    end
    start = 1'b0;
    chk("held_start_done_count", 32'(ndone), 32'd3);
    chk("held_start_overlap", 32'(overlap), 32'd0);
    chk("held_start_hi", 32'(result_hi), 32'd0);
    chk("held_start_lo", 32'(result_lo), 32'd42);
    repeat (12) @(posedge CLK);

    // Reset asserted at E4 of a running multiply
    @(negedge CLK);
    op = 4'b0011; a = 8'd13; b = 8'd11; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    Reset_n = 1'b0;
    @(posedge CLK); #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", 32'(result_hi), 32'd0);
    chk("abort_lo", 32'(result_lo), 32'd0);
    @(negedge CLK);
    Reset_n = 1'b1;
    ndone = 0;
    hold_lo = result_lo;
    for (int e = 0; e < 12; e++) begin
      @(posedge CLK); #1;
      if (done || busy) ndone++;
    end
    chk("abort_no_activity", 32'(ndone), 32'd0);
    chk("abort_lo_stays", 32'(result_lo), 32'(hold_lo));

    // Start coinciding with reset is dropped
    @(negedge CLK);
    Reset_n = 1'b0; start = 1'b1; op = 4'b0011; a = 8'd1; b = 8'd1;
    @(posedge CLK); #1;
    start = 1'b0; Reset_n = 1'b1;
    @(posedge CLK); #1;
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_done", 32'(done), 32'd0);

    run_op(4'b0010, 8'd200, 8'd7, lat, nbusy, overlap);
    chk("post_abort_latency", 32'(lat), 32'd8);
    chk("post_abort_hi", 32'(result_hi), 32'h04);
    chk("post_abort_lo", 32'(result_lo), 32'h1C);
    chk("post_abort_flags", 32'({div_by_zero, op_err}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative unsigned multiply/divide engine that executes the ALU's MUL (4'b0011) and DIV (4'b0010) opcodes.
- The single-cycle ALU hands off operands and opcode with a start pulse, stalls on busy, and takes results on the done pulse.
- One bit is processed per clock: shift-add for multiply, restoring division for divide.

Parameters:
W, 8, operand width in bits; result is 2W bits split into hi/lo halves.

Ports:
CLK  in  1  system clock, all state updates on rising edge
Reset_n  in  1  synchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
op  in  4  opcode; MUL=4'b0011, DIV=4'b0010, anything else is illegal
a  in  W  multiplicand / dividend (unsigned)
b  in  W  multiplier / divisor (unsigned)
busy  out  1  high while in RUN
done  out  1  one-cycle completion pulse
result_hi  out  W  MUL: product[2W-1:W]; DIV: remainder
result_lo  out  W  MUL: product[W-1:0]; DIV: quotient
div_by_zero  out  1  DIV with b==0, valid with done, held with results
op_err  out  1  illegal op accepted, valid with done, held with results

Behaviour:
- One clock domain. Reset is synchronous and active-low (Reset_n sampled on CLK rising edge).
- Reset values:
  - state=IDLE; busy=0, done=0.
  - result_hi=0, result_lo=0, div_by_zero=0, op_err=0.
  - Iteration counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1, latch a, b, op. Call this edge E0.
  - op=MUL, or op=DIV with b!=0 -> RUN, counter=0; clear div_by_zero and op_err.
  - op=DIV with b==0 -> DONE directly. result_lo={W{1'b1}}, result_hi=a, div_by_zero=1, op_err=0.
  - Any other op -> DONE directly. result_hi=0, result_lo=0, op_err=1, div_by_zero=0.
  - start=0 -> stay in IDLE; outputs hold.
- RUN:
  - Exactly W iterations, one per edge E1..EW. Counter increments each edge.
  - On the edge where counter==W-1: write final results, go to DONE.
  - MUL: 2W-bit accumulator. Each iteration, if multiplier LSB=1, add multiplicand to the upper half; then shift accumulator+multiplier right one bit. Carry out of the add must be kept (W+1-bit adder).
  - DIV: remainder register R (W+1 bits), quotient Q. Each iteration, shift {R,Q} left with the next dividend MSB into R.
    - If R>=b: R=R-b and Q LSB=1.
    - Else: Q LSB=0.
  - busy=1 for the whole state. start is ignored and does not restart the operation.
  - a, b, op may change freely; latched copies are used.
- DONE:
  - done=1 for exactly one cycle, then IDLE unconditionally.
  - start during DONE is ignored.
- Latency, with start sampled at edge E0:
  - Normal path: done high in the cycle after edge EW (W cycles after the start edge). Next start can be accepted at edge EW+2.
  - Fast paths (b==0, illegal op): done high in the cycle immediately after E0.
- Result outputs:
  - Update only when entering DONE.
  - Hold until the next accepted start's completion.
  - Intermediate values are never visible on result_hi/result_lo.
- Arithmetic: fully unsigned. W×W product fits 2W bits exactly, so no overflow flag. Remainder is always < b.
- Reset mid-operation (Reset_n=0 in RUN or DONE):
  - Next edge -> IDLE with all outputs at reset values.
  - Any pending done is suppressed.
- start and Reset_n=0 on the same edge: reset wins, request dropped.
- busy and done are never high in the same cycle.

Test Plan:
- MUL a=13, b=11 -> done in cycle after E8, result_hi=8'h00, result_lo=8'h8F; busy high for cycles E0..E8 exactly, flags 0.
- MUL a=255, b=255 -> result_hi=8'hFE, result_lo=8'h01, confirming carry retention; then MUL a=0, b=200 -> 16'h0000.
- DIV a=200, b=7 -> result_lo=8'h1C (28), result_hi=8'h04; DIV a=5, b=9 -> result_lo=0, result_hi=5; DIV a=255, b=1 -> result_lo=8'hFF, result_hi=0.
- DIV a=8'h2A, b=0 -> done in cycle after E0, result_lo=8'hFF, result_hi=8'h2A, div_by_zero=1, busy never high. Following MUL 3×4 -> div_by_zero cleared, result_lo=8'h0C.
- op=4'b0001 (ADD) with start -> done next cycle, op_err=1, results 0. Then start held high continuously with op=MUL -> exactly one operation per IDLE visit, with no starts accepted in RUN/DONE.
- MUL 13×11 started, Reset_n=0 at E4 -> next cycle busy=0, done never pulses, results 0. Fresh DIV 200/7 afterwards completes correctly.
